pal_write_ctrl: RTL and testbench
=================================

Name: pal_write_ctrl

Overview:
- CPU-side writer for the 256x16 palette RAM.
- Assembles 16-bit palette entries from 8-bit CPU writes and auto-increments the palette index.
- Queues completed entries in a small FIFO.
- Drains the FIFO into the RAM write port (rising-edge PAL_WR) only while the video fetch path is not using the RAM.

Parameters:
DEPTH, 4, pending-entry FIFO depth (power of 2, >=2)

Ports:
CLK  input  1  system clock, all state on rising edge
RESETn  input  1  asynchronous active-low reset
CPU_WR  input  1  one-cycle CPU write strobe
CPU_ADDR  input  2  register select: 0 index, 1 data low, 2 data high (commit), 3 status
CPU_DI  input  8  CPU write data
CPU_DO  output  8  CPU read data, combinational from CPU_ADDR
VID_BUSY  input  1  video is reading palette RAM; no write may start
PAL_A  output  8  palette RAM address
PAL_DI  output  16  palette RAM write data
PAL_WR  output  1  palette RAM write strobe; RAM captures on its rising edge
FULL  output  1  FIFO full
PAL_DO  input  16  palette RAM read data (only with PAL_READBACK_EN)

Behaviour:
- Reset (async, RESETn=0) values:
  - index=0x00, low latch=0x00, FIFO empty, OVF=0, state IDLE.
  - PAL_WR=0, PAL_A=0x00, PAL_DI=0x0000, FULL=0.
- CPU writes are registered on the CLK edge with CPU_WR=1:
  - ADDR0: index<=CPU_DI.
  - ADDR1: low latch<=CPU_DI.
  - ADDR2: if not full, push {index, CPU_DI, low latch} and set index<=index+1. Index wraps 0xFF->0x00; low latch is retained. If full, the entry is dropped, OVF<=1 (sticky) and index is unchanged. A push while full is dropped even if a pop occurs on the same edge.
  - ADDR3: if CPU_DI[2]=1, OVF<=0; other bits ignored.
- CPU_DO by CPU_ADDR:
  - 0: index.
  - 3: {4'b0, ACTIVE, OVF, FULL, EMPTY}, where ACTIVE=(state!=IDLE).
  - 1 and 2: 0x00 unless readback is enabled (see Optional Feature).
- Drain FSM, one state per cycle:
  - IDLE: go to SETUP when FIFO non-empty and VID_BUSY=0, both sampled at the edge.
  - SETUP: PAL_A/PAL_DI=FIFO head, PAL_WR=0. If VID_BUSY=1, return to IDLE with no strobe and no pop; otherwise go to STROBE.
  - STROBE: PAL_WR=1 with A/DI held. Always goes to HOLD; VID_BUSY is ignored. Pop occurs on the STROBE->HOLD edge.
  - HOLD: PAL_WR=0, A/DI held from the popped entry. Go to IDLE.
  - In IDLE, PAL_A=index and PAL_DI is held at its last value.
- Latency: commit registered at edge N; SETUP after edge N+1; PAL_WR high after edge N+2; low after edge N+3; IDLE after edge N+4. Minimum 4 cycles per entry; back-to-back entries run with no extra gap (HOLD->IDLE->SETUP).
- FULL and EMPTY reflect the registered FIFO count.
- Index writes during a drain affect future pushes only.
- Reset mid-drain: PAL_WR drops immediately (async) and pending entries are discarded.

Optional Feature:
- Macro: PAL_READBACK_EN.
- Defined:
  - PAL_DO port exists.
  - CPU_DO for ADDR1 = PAL_DO[7:0], ADDR2 = PAL_DO[15:8], for the entry at index.
  - Data is valid only while ACTIVE=0, since PAL_A tracks the FIFO head during a drain.
- Undefined: PAL_DO port absent; ADDR1/ADDR2 read 0x00.

Test Plan:
- Reset, write idx=0x10, lo=0x34, hi=0x12, VID_BUSY=0 -> single PAL_WR pulse 2 cycles after commit with PAL_A=0x10, PAL_DI=0x1234; index reads 0x11; status=0x01 afterwards.
- idx=0xFF, commit two entries 0xAAAA, 0x5555 -> writes to 0xFF then 0x00, 4 cycles apart; index=0x01.
- VID_BUSY=1, commit DEPTH+1 entries -> no PAL_WR; FULL=1; status=0x06 (OVF, FULL); index advanced by DEPTH only; write ADDR3=0x04 clears OVF.
- Hold VID_BUSY=1, then release for 1 cycle so the FSM enters SETUP, then reassert -> return to IDLE, no strobe, FIFO count unchanged; after final release the entry writes once.
- Assert RESETn=0 during STROBE -> PAL_WR=0 immediately; FIFO empty, index=0x00; no further strobes.
- PAL_READBACK_EN: PAL_DO=0xBEEF while idle -> ADDR1 reads 0xEF, ADDR2 reads 0xBE; without macro both read 0x00.

Source files
------------

// File: rtl/pal_write_ctrl.sv
// CPU-side palette writer: builds 16-bit entries from byte writes, queues them in a
// small FIFO and drains them into the palette RAM around video fetches. Optional macro: PAL_READBACK_EN.
module pal_write_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        CPU_WR,
  input  logic [1:0]  CPU_ADDR,
  input  logic [7:0]  CPU_DI,
  output logic [7:0]  CPU_DO,
  input  logic        VID_BUSY,
  output logic [7:0]  PAL_A,
  output logic [15:0] PAL_DI,
  output logic        PAL_WR,
  output logic        FULL
`ifdef PAL_READBACK_EN
  ,
  input  logic [15:0] PAL_DO
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [7:0]    index_q, index_d;
  logic [7:0]    lo_q, lo_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [23:0]   fifo_q [DEPTH];
  logic [7:0]    pal_a_q, pal_a_d;
  logic [15:0]   pal_di_q, pal_di_d;
  logic          pal_wr_q, pal_wr_d;

  logic          full, empty, push, pop;
  logic          wr_idx, wr_lo, wr_hi, wr_stat;
  logic [23:0]   head;

  assign wr_idx  = CPU_WR && (CPU_ADDR == 2'd0);
  assign wr_lo   = CPU_WR && (CPU_ADDR == 2'd1);
  assign wr_hi   = CPU_WR && (CPU_ADDR == 2'd2);
  assign wr_stat = CPU_WR && (CPU_ADDR == 2'd3);

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // A commit while full is dropped even if the same edge pops: full is the registered flag.
  assign push  = wr_hi && !full;
  assign pop   = (state_q == STROBE);
  assign head  = fifo_q[rd_ptr_q];

  always_comb begin
    index_d  = index_q;
    lo_d     = lo_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_idx)     index_d = CPU_DI;
    else if (push)  index_d = index_q + 8'd1;
    if (wr_lo)      lo_d = CPU_DI;
    if (wr_hi && full)             ovf_d = 1'b1;
    else if (wr_stat && CPU_DI[2]) ovf_d = 1'b0;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Drain handshake: an entry is offered when the FIFO is non-empty; VID_BUSY acts as
  // an inverted ready, sampled in IDLE and again in SETUP. Once STROBE is reached the
  // write completes regardless of VID_BUSY and the entry is popped on leaving STROBE.
  always_comb begin
    state_d  = state_q;
    pal_a_d  = pal_a_q;
    pal_di_d = pal_di_q;
    case (state_q)
      IDLE:   if (!empty && !VID_BUSY) state_d = SETUP;
      SETUP: begin
        pal_a_d  = head[23:16];
        pal_di_d = head[15:0];
        state_d  = VID_BUSY ? IDLE : STROBE;
      end
      STROBE: state_d = HOLD;
      HOLD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pal_wr_d = (state_d == STROBE);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= IDLE;
      index_q  <= 8'h00;
      lo_q     <= 8'h00;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pal_a_q  <= 8'h00;
      pal_di_q <= 16'h0000;
      pal_wr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= 24'h0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      lo_q     <= lo_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pal_a_q  <= pal_a_d;
      pal_di_q <= pal_di_d;
      pal_wr_q <= pal_wr_d;
      if (push) fifo_q[wr_ptr_q] <= {index_q, CPU_DI, lo_q};
    end
  end

  // Idle: address follows the CPU index (for readback); setup shows the head directly.
  always_comb begin
    PAL_A  = pal_a_q;
    PAL_DI = pal_di_q;
    if (state_q == IDLE) begin
      PAL_A = index_q;
    end else if (state_q == SETUP) begin
      PAL_A  = head[23:16];
      PAL_DI = head[15:0];
    end
  end

  assign PAL_WR = pal_wr_q;
  assign FULL   = full;

  always_comb begin
    CPU_DO = 8'h00;
    case (CPU_ADDR)
      2'd0: CPU_DO = index_q;
      2'd3: CPU_DO = {4'b0000, (state_q != IDLE), ovf_q, full, empty};
`ifdef PAL_READBACK_EN
      2'd1: CPU_DO = PAL_DO[7:0];
      2'd2: CPU_DO = PAL_DO[15:8];
`endif
      default: CPU_DO = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_pal_write_ctrl.sv
// Bench for pal_write_ctrl: register-level vector table, scoreboard of palette writes,
// and hand sequences for latency, SETUP abort and reset during a strobe.
module tb_pal_write_ctrl;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        CPU_WR = 1'b0;
  logic [1:0]  CPU_ADDR = 2'd0;
  logic [7:0]  CPU_DI = 8'h00;
  logic [7:0]  CPU_DO;
  logic        VID_BUSY = 1'b0;
  logic [7:0]  PAL_A;
  logic [15:0] PAL_DI;
  logic        PAL_WR;
  logic        FULL;
  logic [15:0] PAL_DO = 16'h0000;

  pal_write_ctrl #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESETn(RESETn), .CPU_WR(CPU_WR), .CPU_ADDR(CPU_ADDR),
    .CPU_DI(CPU_DI), .CPU_DO(CPU_DO), .VID_BUSY(VID_BUSY), .PAL_A(PAL_A),
    .PAL_DI(PAL_DI), .PAL_WR(PAL_WR), .FULL(FULL)
`ifdef PAL_READBACK_EN
    , .PAL_DO(PAL_DO)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int m_cnt = 0;
  logic [7:0] m_index = 8'h00;
  logic [7:0] m_lo = 8'h00;
  int strobe_cnt = 0;
  int prev_strobe_cyc = 0;
  int last_strobe_cyc = 0;
  logic wr_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge CLK) begin
    #2;
    if (PAL_WR && !wr_prev) begin
      strobe_cnt++;
      prev_strobe_cyc = last_strobe_cyc;
      last_strobe_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got A=0x%0h DI=0x%0h expected no write", PAL_A, PAL_DI);
      end else begin
        chk("pal_write", {PAL_A, PAL_DI}, exp_q.pop_front());
        m_cnt--;
      end
    end
    wr_prev = PAL_WR;
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; the write registers on the following rising edge.
  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    CPU_WR = 1'b1;
    CPU_ADDR = a;
    CPU_DI = d;
    if (a == 2'd0) m_index = d;
    else if (a == 2'd1) m_lo = d;
    else if (a == 2'd2 && m_cnt < DEPTH) begin
      exp_q.push_back({m_index, d, m_lo});
      m_cnt++;
      m_index = m_index + 8'd1;
    end
    @(negedge CLK);
    CPU_WR = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [7:0] e, input string nm);
    CPU_ADDR = a;
    #1;
    chk(nm, CPU_DO, e);
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk(nm, exp_q.size(), 0);
    repeat (3) @(negedge CLK);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       wr;
    logic [1:0] a;
    logic [7:0] d;
    logic [1:0] ra;
    logic [7:0] exp_do;
    logic       exp_full;
  } vec_t;

  vec_t vt[11];
  int s0;

  initial begin
    vt[0]  = '{1'b1, 2'd0, 8'h40, 2'd0, 8'h40, 1'b0};
    vt[1]  = '{1'b1, 2'd1, 8'h01, 2'd3, 8'h01, 1'b0};
    vt[2]  = '{1'b1, 2'd2, 8'h11, 2'd0, 8'h41, 1'b0};
    vt[3]  = '{1'b1, 2'd2, 8'h22, 2'd3, 8'h00, 1'b0};
    vt[4]  = '{1'b1, 2'd2, 8'h33, 2'd0, 8'h43, 1'b0};
    vt[5]  = '{1'b1, 2'd2, 8'h44, 2'd3, 8'h02, 1'b1};
    vt[6]  = '{1'b1, 2'd2, 8'h55, 2'd3, 8'h06, 1'b1};
    vt[7]  = '{1'b0, 2'd0, 8'h00, 2'd0, 8'h44, 1'b1};
    vt[8]  = '{1'b1, 2'd3, 8'h03, 2'd3, 8'h06, 1'b1};
    vt[9]  = '{1'b1, 2'd3, 8'h04, 2'd3, 8'h02, 1'b1};
    vt[10] = '{1'b1, 2'd0, 8'h80, 2'd0, 8'h80, 1'b1};

    // reset
    repeat (3) @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    chk("rst_pal_wr", PAL_WR, 1'b0);
    chk("rst_pal_a", PAL_A, 8'h00);
    chk("rst_pal_di", PAL_DI, 16'h0000);
    chk("rst_full", FULL, 1'b0);
    rd_chk(2'd0, 8'h00, "rst_index");
    rd_chk(2'd3, 8'h01, "rst_status");

    // single entry, exact latency
    cpu_write(2'd0, 8'h10);
    cpu_write(2'd1, 8'h34);
    cpu_write(2'd2, 8'h12);
    chk("t1_wr_n0", PAL_WR, 1'b0);
    @(negedge CLK);
    chk("t1_wr_setup", PAL_WR, 1'b0);
    chk("t1_a_setup", PAL_A, 8'h10);
    chk("t1_di_setup", PAL_DI, 16'h1234);
    rd_chk(2'd3, 8'h08, "t1_status_setup");
    @(negedge CLK);
    chk("t1_wr_strobe", PAL_WR, 1'b1);
    chk("t1_a_strobe", PAL_A, 8'h10);
    chk("t1_di_strobe", PAL_DI, 16'h1234);
    @(negedge CLK);
    chk("t1_wr_hold", PAL_WR, 1'b0);
    chk("t1_a_hold", PAL_A, 8'h10);
    rd_chk(2'd3, 8'h09, "t1_status_hold");
    @(negedge CLK);
    rd_chk(2'd3, 8'h01, "t1_status_idle");
    rd_chk(2'd0, 8'h11, "t1_index");
    chk("t1_a_idle", PAL_A, 8'h11);
    chk("t1_di_idle", PAL_DI, 16'h1234);

    // index wrap, back-to-back entries
    cpu_write(2'd0, 8'hFF);
    cpu_write(2'd1, 8'hAA);
    cpu_write(2'd2, 8'hAA);
    cpu_write(2'd1, 8'h55);
    cpu_write(2'd2, 8'h55);
    wait_drain("t2_drain");
    chk("t2_spacing", last_strobe_cyc - prev_strobe_cyc, 4);
    rd_chk(2'd0, 8'h01, "t2_index");

    // table: fill while video busy, overflow, OVF clear, then drain
    VID_BUSY = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (vt[i].wr) cpu_write(vt[i].a, vt[i].d);
      else @(negedge CLK);
      rd_chk(vt[i].ra, vt[i].exp_do, $sformatf("vec%0d_do", i));
      chk($sformatf("vec%0d_full", i), FULL, vt[i].exp_full);
    end
    chk("t3_no_strobe", strobe_cnt, 3);
    VID_BUSY = 1'b0;
    wait_drain("t3_drain");
    rd_chk(2'd3, 8'h01, "t3_status");
    rd_chk(2'd0, 8'h80, "t3_index");

    // SETUP abort when video reclaims the RAM
    VID_BUSY = 1'b1;
    cpu_write(2'd1, 8'h77);
    cpu_write(2'd2, 8'h66);
    VID_BUSY = 1'b0;
    @(negedge CLK);
    VID_BUSY = 1'b1;
    rd_chk(2'd3, 8'h08, "t4_status_setup");
    chk("t4_a_setup", PAL_A, 8'h80);
    @(negedge CLK);
    rd_chk(2'd3, 8'h00, "t4_status_abort");
    chk("t4_wr_abort", PAL_WR, 1'b0);
    s0 = strobe_cnt;
    repeat (10) @(negedge CLK);
    chk("t4_no_strobe", strobe_cnt, s0);
    VID_BUSY = 1'b0;
    wait_drain("t4_drain");
    chk("t4_one_strobe", strobe_cnt, s0 + 1);

    // reset during STROBE
    cpu_write(2'd2, 8'h01);
    cpu_write(2'd2, 8'h02);
    @(negedge CLK);
    chk("t5_wr_strobe", PAL_WR, 1'b1);
    RESETn = 1'b0;
    #1;
    chk("t5_wr_async", PAL_WR, 1'b0);
    exp_q.delete();
    m_cnt = 0;
    m_index = 8'h00;
    m_lo = 8'h00;
    @(negedge CLK);
    RESETn = 1'b1;
    rd_chk(2'd0, 8'h00, "t5_index");
    rd_chk(2'd3, 8'h01, "t5_status");
    s0 = strobe_cnt;
    repeat (20) @(negedge CLK);
    chk("t5_no_strobe", strobe_cnt, s0);

    // readback of registers 1/2 while idle
    PAL_DO = 16'hBEEF;
`ifdef PAL_READBACK_EN
    rd_chk(2'd1, 8'hEF, "t6_rb_lo");
    rd_chk(2'd2, 8'hBE, "t6_rb_hi");
`else
    rd_chk(2'd1, 8'h00, "t6_rb_lo");
    rd_chk(2'd2, 8'h00, "t6_rb_hi");
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
